// File: rtl/echo_fmt_pkg.sv
// Shared types and helpers for the echo formatter.
// Mode codes, FSM encoding, ASCII constants, hex digit conversion.
package echo_fmt_pkg;

  localparam logic [1:0] MODE_RAW   = 2'd0;
  localparam logic [1:0] MODE_HEX   = 2'd1;
  localparam logic [1:0] MODE_HEXSP = 2'd2;
  localparam logic [1:0] MODE_HEXLN = 2'd3;

  localparam logic [7:0] ASC_SP = 8'h20;
  localparam logic [7:0] ASC_CR = 8'h0D;
  localparam logic [7:0] ASC_LF = 8'h0A;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RAW,
    S_HI,
    S_LO,
    S_SEP,
    S_CR,
    S_LF
  } state_t;

  function automatic logic [7:0] nib2asc(
    input logic [3:0] n,
    input logic       upper
  );
    logic [7:0] base;
    if (n < 4'd10) begin
      nib2asc = 8'h30 + {4'h0, n};
    end else begin
      base    = upper ? 8'h41 : 8'h61;
      nib2asc = base + {4'h0, n - 4'd10};
    end
  endfunction

endpackage

// File: rtl/echo_formatter_byte_fifo.sv
// Byte FIFO with power-of-two depth and occupancy output.
// Head byte is visible combinationally on rd_data.
module byte_fifo #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [7:0]    wr_data,
  input  logic          pop,
  output logic [7:0]    rd_data,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty
);

  logic [7:0]    mem [DEPTH];
  logic [LW-1:0] wr_ptr;
  logic [LW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign rd_data = mem[rd_ptr[AW-1:0]];
  assign level   = wr_ptr - rd_ptr;
  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);

endmodule

// File: rtl/echo_formatter.sv
// RX-to-TX byte path: FIFO plus raw/hex formatter.
// Sits between uart_rx and uart_tx; no backpressure on input.
module echo_formatter
  import echo_fmt_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int CNT_W      = 8,
  parameter int LINE_BYTES = 16,
  parameter bit UPPER      = 1'b1,
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic [1:0]       mode,
  output logic             out_en,
  output logic [7:0]       out_data,
  input  logic             out_ack,
  input  logic             clr_ovf,
  output logic             overflow,
  output logic [CNT_W-1:0] rx_count,
  output logic [LW-1:0]    fifo_level,
  output logic             busy
);

  state_t     state, state_nx;
  logic [7:0] hold;
  logic [1:0] mode_q;
  logic [7:0] line_cnt;
  logic [7:0] head;
  logic       full, empty;
  logic       push, pop, drop, ack, line_end;
  logic [LW-1:0] lvl_nx;

  byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .wr_data (in_data),
    .pop     (pop),
    .rd_data (head),
    .level   (fifo_level),
    .full    (full),
    .empty   (empty)
  );

  assign pop      = (state == S_IDLE) && !empty;
  assign push     = in_valid && (!full || pop);
  assign drop     = in_valid && !push;
  assign ack      = out_ack && out_en;
  assign line_end = (line_cnt + 8'd1) == 8'(LINE_BYTES);
  assign lvl_nx   = fifo_level + LW'(push) - LW'(pop);

  always_comb begin
    state_nx = state;
    out_en   = 1'b0;
    out_data = 8'h00;
    unique case (state)
      S_IDLE: begin
        if (pop) state_nx = (mode == MODE_RAW) ? S_RAW : S_HI;
      end
      S_RAW: begin
        out_en   = 1'b1;
        out_data = hold;
        if (ack) state_nx = S_IDLE;
      end
      S_HI: begin
        out_en   = 1'b1;
        out_data = nib2asc(hold[7:4], UPPER);
        if (ack) state_nx = S_LO;
      end
      S_LO: begin
        out_en   = 1'b1;
        out_data = nib2asc(hold[3:0], UPPER);
        if (ack) begin
          unique case (1'b1)
            mode_q == MODE_HEXSP: state_nx = S_SEP;
            mode_q == MODE_HEXLN: state_nx = line_end ? S_CR : S_SEP;
            default:              state_nx = S_IDLE;
          endcase
        end
      end
      S_SEP: begin
        out_en   = 1'b1;
        out_data = ASC_SP;
        if (ack) state_nx = S_IDLE;
      end
      S_CR: begin
        out_en   = 1'b1;
        out_data = ASC_CR;
        if (ack) state_nx = S_LF;
      end
      S_LF: begin
        out_en   = 1'b1;
        out_data = ASC_LF;
        if (ack) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      hold     <= 8'h00;
      mode_q   <= MODE_RAW;
      line_cnt <= 8'h00;
      overflow <= 1'b0;
      rx_count <= '0;
      busy     <= 1'b0;
    end else begin
      state <= state_nx;
      busy  <= (lvl_nx != '0) || (state_nx != S_IDLE);
      if (pop) begin
        hold   <= head;
        mode_q <= mode;
      end
      if (push) rx_count <= rx_count + 1'b1;
      // a drop wins over a same-cycle clear
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
      if (pop && mode != MODE_HEXLN) begin
        line_cnt <= 8'h00;
      end else if (state == S_LO && ack && mode_q == MODE_HEXLN) begin
        line_cnt <= line_end ? 8'h00 : line_cnt + 8'd1;
      end
    end
  end

endmodule

// File: doc/echo_formatter.md
# echo_formatter

Parametrised receive-to-transmit byte path for the UART loopback designs: buffers bytes from the UART receiver in a FIFO and emits them to the UART transmitter either raw or as ASCII hex with optional separators and line breaks. It replaces the fixed-depth queue plus hex-encoder pair and adds a runtime mode select, a received-byte counter, a FIFO level output and a clearable overflow flag. It sits between `uart_rx` (`data_ready`/`data`) and `uart_tx` (`en`/`data_in`/`ack`).

## Interface
- `DEPTH`, 16: FIFO depth in bytes; power of two, ≥ 2.
- `CNT_W`, 8: width of the received-byte counter.
- `LINE_BYTES`, 16: bytes per line in mode 3; 1–255.
- `UPPER`, 1: 1 = hex digits A–F, 0 = a–f.

Ports:
- `clk` in 1: single clock; all logic is on its rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `in_valid` in 1: one-cycle strobe, byte present on `in_data`; there is no backpressure.
- `in_data` in 8: received byte.
- `mode` in 2: 0 raw, 1 hex, 2 hex+space, 3 hex+space+CRLF per line.
- `out_en` out 1: byte valid to transmitter; held until acked.
- `out_data` out 8: byte to transmit; stable while `out_en`.
- `out_ack` in 1: one-cycle strobe from transmitter, byte consumed.
- `clr_ovf` in 1: clears `overflow`.
- `overflow` out 1: sticky; a byte was dropped.
- `rx_count` out CNT_W: accepted-byte counter, wraps.
- `fifo_level` out $clog2(DEPTH)+1: current FIFO occupancy.
- `busy` out 1: FIFO non-empty or FSM not IDLE.

## Operation
- Reset (async, `rst_n`=0): FIFO empty, `fifo_level`=0, `out_en`=0, `out_data`=0, `overflow`=0, `rx_count`=0, `busy`=0, FSM=IDLE, line counter=0.
- Push: `in_valid` writes `in_data` if level<DEPTH, or if level==DEPTH and a pop occurs the same cycle. Otherwise the byte is dropped and `overflow` is set. Only accepted bytes increment `rx_count` (mod 2^CNT_W).
- `overflow`: set beats clear when a drop and `clr_ovf` occur in the same cycle.
- FSM states: IDLE, RAW, HI, LO, SEP, CR, LF.
- IDLE with FIFO non-empty:
  - pops the head into a hold register;
  - samples `mode` (mode is sampled only here);
  - goes to RAW (mode 0) or HI (modes 1–3).
- Each non-IDLE state drives `out_en`=1 with its character and advances on `out_ack`:
  - RAW→IDLE.
  - HI→LO.
  - LO→IDLE (mode 1), LO→SEP (mode 2), LO→SEP or CR (mode 3).
  - SEP→IDLE.
  - CR→LF.
  - LF→IDLE.
- Characters:
  - RAW: the held byte.
  - HI/LO: hex of `hold[7:4]`/`hold[3:0]`, 0x30–0x39 then 0x41–0x46 (UPPER=1) or 0x61–0x66 (UPPER=0).
  - SEP: 0x20.
  - CR: 0x0D.
  - LF: 0x0A.
- Mode 3 line counter: incremented at LO ack. When it reaches LINE_BYTES, LO goes to CR instead of SEP and the counter clears. The counter also clears whenever a byte is popped with `mode`≠3.
- `out_ack` while `out_en`=0 is ignored.

## Timing
- `in_valid` in cycle t into an empty FIFO with FSM IDLE: `fifo_level`=1 at t+1, pop at the end of t+1, `out_en`=1 from t+2.
- `out_ack` in cycle a: the next character (or `out_en`=0) from a+1; there is never a back-to-back `out_en` across two bytes without an IDLE cycle.
- `fifo_level` and `busy` are registered and reflect the state after each edge.
- Reset mid-transfer: `out_en` drops asynchronously; the partial character sequence is abandoned.

## Structure
- Shared package `echo_fmt_pkg`:
  - mode constants MODE_RAW/HEX/HEXSP/HEXLN;
  - FSM state encoding;
  - ASCII constants SP, CR, LF;
  - nibble-to-ASCII function.
- Sub-module `byte_fifo` (DEPTH, async active-low reset, push/pop, level, full/empty). The formatter FSM, counters and overflow logic live in `echo_formatter`.

## Test plan
- Mode 1, push 0x3A: `out_data` sequence "3","A" (0x33, 0x41); `rx_count`=1; `out_en` low afterwards.
- Mode 3, LINE_BYTES=2, push 0x00, 0xFF, 0x10: output 0x30 0x30 0x20 0x46 0x46 0x0D 0x0A 0x31 0x30 0x20.
- DEPTH=4, ack never given, push 6 bytes: `fifo_level`=4, `overflow`=1, `rx_count`=5 (one byte in hold). A simultaneous drop and `clr_ovf` leaves `overflow`=1.
- FIFO full, push in the same cycle as the pop: byte accepted, `overflow` stays 0, level stays 4.
- Mode 0, push 0x41 with UPPER=0, then switch mode to 1 mid-byte: raw 0x41 emitted unchanged; the next byte 0xAB emits "a","b".
- Assert `rst_n`=0 during HI with 3 bytes queued: `out_en`=0 immediately, level 0, `rx_count`=0; after release, no output until a new push.
